// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream framing stage: packet FSM states,
// header field widths and a helper that packs the header identification fields.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PAYLOAD  = 2'd1,
        CHECKSUM = 2'd2
    } pkt_state_e;

    localparam int SEQ_WIDTH = 8;
    localparam int TAG_WIDTH = 8;

    // Packs the tag and sequence number into the 16 identification bits of a
    // header word; the top level spreads them to the MSB/LSB ends of the word.
    function automatic logic [TAG_WIDTH+SEQ_WIDTH-1:0] header_fields(
        input logic [TAG_WIDTH-1:0] tag,
        input logic [SEQ_WIDTH-1:0] seq
    );
        return {tag, seq};
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Registered AXI-Stream output stage: holds valid/data/last stable while the
// downstream stalls and reports when a new word may be loaded.
module stream_out_reg #(
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load,
    input  logic [DATA_SIZE-1:0] next_data,
    input  logic                 next_last,
    input  logic                 out_tready,
    output logic [DATA_SIZE-1:0] out_tdata,
    output logic                 out_tvalid,
    output logic                 out_tlast,
    output logic                 slot_free
);

    logic [DATA_SIZE-1:0] tdata_r;
    logic                 tvalid_r;
    logic                 tlast_r;

    assign slot_free  = !tvalid_r || out_tready;
    assign out_tdata  = tdata_r;
    assign out_tvalid = tvalid_r;
    assign out_tlast  = tlast_r;

    // Output register: replace the word when the slot frees, otherwise hold it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tdata_r  <= '0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else if (slot_free) begin
            if (load) begin
                tdata_r  <= next_data;
                tvalid_r <= 1'b1;
                tlast_r  <= next_last;
            end else begin
                tvalid_r <= 1'b0;
            end
        end else begin
            tdata_r  <= tdata_r;
            tvalid_r <= tvalid_r;
            tlast_r  <= tlast_r;
        end
    end

endmodule

// File: rtl/stream_packetizer.sv
// Frames raw FIFO words into fixed-length packets: header, PAYLOAD_LEN payload
// words, then a modular-sum checksum word marked with tlast.
module stream_packetizer
    import stream_pkg::*;
#(
    parameter int          DATA_SIZE   = 16,
    parameter int          PAYLOAD_LEN = 4,
    parameter logic [7:0]  HEADER_TAG  = 8'hA5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATA_SIZE-1:0] data_in_tdata,
    input  logic                 data_in_tvalid,
    output logic                 data_in_tready,
    output logic [DATA_SIZE-1:0] data_out_tdata,
    output logic                 data_out_tvalid,
    input  logic                 data_out_tready,
    output logic                 data_out_tlast,
    output logic                 busy
);

    localparam int CNT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_LEN - 1);

    pkt_state_e           state_r;
    logic [CNT_W-1:0]     word_cnt_r;
    logic [DATA_SIZE-1:0] sum_r;
    logic [SEQ_WIDTH-1:0] seq_r;

    logic                            slot_free_s;
    logic                            in_ready_s;
    logic                            accept_s;
    logic                            load_s;
    logic [DATA_SIZE-1:0]            next_data_s;
    logic                            next_last_s;
    logic [DATA_SIZE-1:0]            header_s;
    logic [TAG_WIDTH+SEQ_WIDTH-1:0]  hdr_fields_s;
    logic                            out_tvalid_s;

    assign data_in_tready = in_ready_s;
    assign data_out_tvalid = out_tvalid_s;
    assign busy = (state_r != IDLE) || out_tvalid_s;
    assign accept_s = data_in_tvalid && in_ready_s;

    // Header word: tag in the MSBs, sequence number in the LSBs, zeros between.
    always_comb begin
        hdr_fields_s = header_fields(HEADER_TAG, seq_r);
        header_s = '0;
        header_s[DATA_SIZE-1 -: TAG_WIDTH] = hdr_fields_s[TAG_WIDTH+SEQ_WIDTH-1:SEQ_WIDTH];
        header_s[SEQ_WIDTH-1:0] = hdr_fields_s[SEQ_WIDTH-1:0];
    end

    // Input handshake and selection of the next word for the output register.
    always_comb begin
        in_ready_s  = 1'b0;
        load_s      = 1'b0;
        next_data_s = '0;
        next_last_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s      = data_in_tvalid && slot_free_s;
                next_data_s = header_s;
            end
            PAYLOAD: begin
                if (rst_ni) begin
                    in_ready_s = slot_free_s;
                end else begin
                    in_ready_s = 1'b0;
                end
                load_s      = data_in_tvalid && in_ready_s;
                next_data_s = data_in_tdata;
            end
            CHECKSUM: begin
                load_s      = slot_free_s;
                next_data_s = sum_r;
                next_last_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                load_s      = 1'b0;
                next_data_s = '0;
                next_last_s = 1'b0;
            end
        endcase
    end

    // Packet sequencing: state, payload word count, checksum and sequence number.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            word_cnt_r <= '0;
            sum_r      <= '0;
            seq_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (data_in_tvalid && slot_free_s) begin
                        state_r    <= PAYLOAD;
                        word_cnt_r <= '0;
                        sum_r      <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (accept_s) begin
                        sum_r <= sum_r + data_in_tdata;
                        if (word_cnt_r == LAST_CNT) begin
                            word_cnt_r <= '0;
                            state_r    <= CHECKSUM;
                        end else begin
                            word_cnt_r <= word_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= PAYLOAD;
                    end
                end
                CHECKSUM: begin
                    if (slot_free_s) begin
                        seq_r   <= seq_r + SEQ_WIDTH'(1);
                        state_r <= IDLE;
                    end else begin
                        state_r <= CHECKSUM;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    stream_out_reg #(
        .DATA_SIZE (DATA_SIZE)
    ) u_out_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load       (load_s),
        .next_data  (next_data_s),
        .next_last  (next_last_s),
        .out_tready (data_out_tready),
        .out_tdata  (data_out_tdata),
        .out_tvalid (out_tvalid_s),
        .out_tlast  (data_out_tlast),
        .slot_free  (slot_free_s)
    );

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed bench for stream_packetizer: a cycle table for reset, back-to-back
// framing and downstream stall, then hand-written sequences for checksum
// wrap, input gaps, mid-packet reset and sequence-number wrap.
module tb_stream_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] tb_seq;
    logic [16:0] beats[$];

    always #5 clk = ~clk;

    stream_packetizer #(
        .DATA_SIZE   (16),
        .PAYLOAD_LEN (4),
        .HEADER_TAG  (8'hA5)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .data_in_tdata   (in_data),
        .data_in_tvalid  (in_valid),
        .data_in_tready  (in_ready),
        .data_out_tdata  (out_data),
        .data_out_tvalid (out_valid),
        .data_out_tready (out_ready),
        .data_out_tlast  (out_last),
        .busy            (busy)
    );

    // Records every output beat handed over to the downstream.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            beats.push_back({out_last, out_data});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [15:0] din;
        logic        ordy;
        logic        cd;
        logic        irdy;
        logic        ovld;
        logic [15:0] odata;
        logic        olast;
        logic        busy;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input int gap);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (in_ready === 1'b1) begin
                done = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end
        if (gap > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            chk({name, ".idle_timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic send_packet(input logic [3:0][15:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_word(w[k], gap);
        end
        wait_idle("pkt");
    endtask

    task automatic check_packet(input string name, input logic [3:0][15:0] w, input logic [7:0] s);
        logic [16:0] exp_beat[6];
        logic [15:0] sum_m;
        sum_m = 16'h0000;
        exp_beat[0] = {1'b0, 8'hA5, s};
        for (int k = 0; k < 4; k++) begin
            exp_beat[k + 1] = {1'b0, w[k]};
            sum_m = sum_m + w[k];
        end
        exp_beat[5] = {1'b1, sum_m};
        chk({name, ".beats"}, 32'(beats.size()), 32'd6);
        if (beats.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("%s.beat%0d", name, k), 32'(beats[k]), 32'(exp_beat[k]));
            end
        end
    endtask

    initial begin
        logic [3:0][15:0] pw;
        bit saw_last;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        out_ready = 1'b1;
        @(posedge clk);

        //          rst   vld   din       ordy  cd    irdy  ovld  odata     olast busy
        vecs[0]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA500, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA501, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst_n     = vecs[i].rst_n;
            in_valid  = vecs[i].vld;
            in_data   = vecs[i].din;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].irdy));
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].ovld));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            if (vecs[i].cd) begin
                chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].odata));
                chk($sformatf("vec%0d.out_last", i), 32'(out_last), 32'(vecs[i].olast));
            end
        end
        tb_seq = 8'd2;

        // Checksum wrap, back-to-back then with 2-cycle input gaps.
        pw = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        beats.delete();
        send_packet(pw, 0);
        check_packet("wrap_b2b", pw, tb_seq);
        if (beats.size() == 6) chk("wrap_b2b.checksum", 32'(beats[5]), {15'd0, 1'b1, 16'hFFFC});
        tb_seq = tb_seq + 8'd1;
        beats.delete();
        send_packet(pw, 2);
        check_packet("wrap_gap", pw, tb_seq);
        tb_seq = tb_seq + 8'd1;

        // Mid-packet reset after two payload words.
        beats.delete();
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst.in_ready_gated", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        saw_last = 1'b0;
        foreach (beats[k]) if (beats[k][16]) saw_last = 1'b1;
        chk("midrst.beats", 32'(beats.size()), 32'd2);
        chk("midrst.no_tlast", 32'(saw_last), 32'd0);
        tb_seq = 8'd0;
        pw = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        beats.delete();
        send_packet(pw, 0);
        check_packet("after_rst", pw, tb_seq);
        if (beats.size() == 6) begin
            chk("after_rst.header", 32'(beats[0]), 32'h0000A500);
            chk("after_rst.checksum", 32'(beats[5]), 32'h000100A0);
        end

        // 257 packets from reset: sequence number wraps 255 -> 0.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tb_seq = 8'd0;
        for (int p = 0; p < 257; p++) begin
            for (int k = 0; k < 4; k++) begin
                pw[k] = 16'(p * 7 + k * 4099);
            end
            beats.delete();
            send_packet(pw, 0);
            check_packet($sformatf("seq%0d", p), pw, tb_seq);
            if (beats.size() > 0) begin
                if (p == 254) chk("seqwrap.hdr254", 32'(beats[0][15:0]), 32'h0000A5FE);
                if (p == 255) chk("seqwrap.hdr255", 32'(beats[0][15:0]), 32'h0000A5FF);
                if (p == 256) chk("seqwrap.hdr256", 32'(beats[0][15:0]), 32'h0000A500);
            end
            tb_seq = tb_seq + 8'd1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
